// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morra_pkg
// Description : Shared move/result codes, FSM states and helpers for morra.
// Revision    : 1.0 - initial release
// ============================================================================
package morra_pkg;

    localparam logic [1:0] c_MV_ILLEGAL     = 2'b00;
    localparam logic [1:0] c_MV_A           = 2'b01;
    localparam logic [1:0] c_MV_B           = 2'b10;
    localparam logic [1:0] c_MV_C           = 2'b11;

    localparam logic [1:0] c_MANCHE_INVALID = 2'b00;
    localparam logic [1:0] c_MANCHE_P1      = 2'b01;
    localparam logic [1:0] c_MANCHE_P2      = 2'b10;
    localparam logic [1:0] c_MANCHE_DRAW    = 2'b11;

    localparam logic [1:0] c_PARTITA_RUN    = 2'b00;
    localparam logic [1:0] c_PARTITA_P1     = 2'b01;
    localparam logic [1:0] c_PARTITA_P2     = 2'b10;
    localparam logic [1:0] c_PARTITA_DRAW   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_FINISH = 2'd3
    } morra_state_e;

    localparam logic [1:0] c_S_IDLE   = ST_IDLE;
    localparam logic [1:0] c_S_INIT   = ST_INIT;
    localparam logic [1:0] c_S_PLAY   = ST_PLAY;
    localparam logic [1:0] c_S_FINISH = ST_FINISH;

    localparam int         MIN_ROUNDS     = 4;
    localparam int         TIMEOUT_ROUNDS = 20;
    localparam logic [7:0] c_LFSR_RESET   = 8'hA5;
    localparam logic [4:0] c_CNT_MAX      = 5'd31;

    function automatic logic beats(input logic [1:0] p, input logic [1:0] s);
        return ((p == c_MV_B) && (s == c_MV_A)) ||
               ((p == c_MV_A) && (s == c_MV_C)) ||
               ((p == c_MV_C) && (s == c_MV_B));
    endfunction

    function automatic logic [1:0] manche_of(input logic [1:0] p, input logic [1:0] s);
        if ((p == c_MV_ILLEGAL) || (s == c_MV_ILLEGAL)) return c_MANCHE_INVALID;
        if (p == s)                                     return c_MANCHE_DRAW;
        if (beats(p, s))                                return c_MANCHE_P1;
        return c_MANCHE_P2;
    endfunction

    // Map a raw 2-bit candidate to a legal move that avoids the banned one.
    function automatic logic [1:0] pick_move(input logic [1:0] raw, input logic [1:0] ban);
        logic [1:0] c;
        c = (raw == c_MV_ILLEGAL) ? c_MV_C : raw;
        if (c == ban) begin
            case (c)
                c_MV_A:  c = c_MV_B;
                c_MV_B:  c = c_MV_C;
                default: c = c_MV_A;
            endcase
        end
        return c;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == c_CNT_MAX) ? v : v + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morra_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : morra_lfsr
// Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with load and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_lfsr
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_en,
    output logic [3:0] o_low
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_LFSR_RESET;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_low = r_lfsr[3:0];

endmodule
`default_nettype wire

// File: rtl/morra_giocatore.sv
`default_nettype none
// ============================================================================
// Module      : morra_giocatore
// Description : Two-player morra move generator checked against a referee.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_giocatore
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] CFG_LEN,
    input  logic [7:0] SEED,
    input  logic       INJ_INVALID,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIO,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] RESULT,
    output logic [4:0] ROUNDS,
    output logic [4:0] WINS1,
    output logic [4:0] WINS2,
    output logic       ERR
);

    logic [1:0] r_state;
    logic [1:0] r_primo, r_secondo, r_result;
    logic       r_inizio, r_busy, r_done, r_err, r_inj;
    logic [4:0] r_rounds, r_wins1, r_wins2;
    logic [1:0] r_ban1, r_ban2, r_pcnt;

    logic       w_start_ok, w_in_play, w_game_over, w_timeout, w_load_moves;
    logic [7:0] w_seed;
    logic [3:0] w_lfsr_low;
    logic [1:0] w_ban1_nx, w_ban2_nx, w_mv1, w_mv2, w_exp_manche, w_pcnt_nx;
    logic [4:0] w_rounds_nx, w_wins1_nx, w_wins2_nx;

    assign w_start_ok  = (r_state == c_S_IDLE) && START;
    assign w_in_play   = (r_state == c_S_PLAY);
    assign w_seed      = (SEED == 8'h00) ? c_LFSR_RESET : SEED;

    assign w_exp_manche = manche_of(r_primo, r_secondo);
    assign w_rounds_nx  = (w_in_play && (MANCHE != c_MANCHE_INVALID)) ? sat_inc(r_rounds) : r_rounds;
    assign w_wins1_nx   = (w_in_play && (MANCHE == c_MANCHE_P1)) ? sat_inc(r_wins1) : r_wins1;
    assign w_wins2_nx   = (w_in_play && (MANCHE == c_MANCHE_P2)) ? sat_inc(r_wins2) : r_wins2;

    assign w_game_over  = w_in_play && (PARTITA != c_PARTITA_RUN);
    assign w_timeout    = w_in_play && (PARTITA == c_PARTITA_RUN) &&
                          (w_rounds_nx >= 5'(TIMEOUT_ROUNDS));
    assign w_load_moves = (r_state == c_S_INIT) || (w_in_play && !w_game_over && !w_timeout);

    // Restriction follows the round just sampled, so the next pair sees it at once.
    always_comb begin
        w_ban1_nx = r_ban1;
        w_ban2_nx = r_ban2;
        if (w_in_play) begin
            case (MANCHE)
                c_MANCHE_P1:   w_ban1_nx = r_primo;
                c_MANCHE_P2:   w_ban2_nx = r_secondo;
                c_MANCHE_DRAW: begin
                    w_ban1_nx = c_MV_ILLEGAL;
                    w_ban2_nx = c_MV_ILLEGAL;
                end
                default: ;
            endcase
        end
    end

    assign w_pcnt_nx = (r_pcnt == 2'd3) ? r_pcnt : r_pcnt + 2'd1;
    assign w_mv1     = (r_inj && (r_pcnt == 2'd2)) ? c_MV_ILLEGAL : pick_move(w_lfsr_low[1:0], w_ban1_nx);
    assign w_mv2     = pick_move(w_lfsr_low[3:2], w_ban2_nx);

    morra_lfsr u_lfsr (
        .clk    (clk),
        .rst    (RST),
        .i_load (w_start_ok),
        .i_seed (w_seed),
        .i_en   (w_load_moves),
        .o_low  (w_lfsr_low)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= c_S_IDLE;
            r_primo   <= 2'b00;
            r_secondo <= 2'b00;
            r_result  <= 2'b00;
            r_inizio  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_inj     <= 1'b0;
            r_rounds  <= 5'd0;
            r_wins1   <= 5'd0;
            r_wins2   <= 5'd0;
            r_ban1    <= 2'b00;
            r_ban2    <= 2'b00;
            r_pcnt    <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (START) begin
                        r_state   <= c_S_INIT;
                        r_inizio  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_primo   <= CFG_LEN[3:2];
                        r_secondo <= CFG_LEN[1:0];
                        r_result  <= 2'b00;
                        r_err     <= 1'b0;
                        r_inj     <= INJ_INVALID;
                        r_rounds  <= 5'd0;
                        r_wins1   <= 5'd0;
                        r_wins2   <= 5'd0;
                        r_ban1    <= 2'b00;
                        r_ban2    <= 2'b00;
                        r_pcnt    <= 2'd0;
                    end
                end
                c_S_INIT: begin
                    r_state   <= c_S_PLAY;
                    r_inizio  <= 1'b0;
                    r_primo   <= w_mv1;
                    r_secondo <= w_mv2;
                    r_pcnt    <= w_pcnt_nx;
                end
                c_S_PLAY: begin
                    r_rounds <= w_rounds_nx;
                    r_wins1  <= w_wins1_nx;
                    r_wins2  <= w_wins2_nx;
                    r_ban1   <= w_ban1_nx;
                    r_ban2   <= w_ban2_nx;
                    if ((MANCHE != w_exp_manche) || w_timeout) begin
                        r_err <= 1'b1;
                    end
                    if (w_game_over || w_timeout) begin
                        r_state   <= c_S_FINISH;
                        r_result  <= w_game_over ? PARTITA : c_PARTITA_RUN;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_primo   <= 2'b00;
                        r_secondo <= 2'b00;
                    end else begin
                        r_primo   <= w_mv1;
                        r_secondo <= w_mv2;
                        r_pcnt    <= w_pcnt_nx;
                    end
                end
                c_S_FINISH: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign PRIMO   = r_primo;
    assign SECONDO = r_secondo;
    assign INIZIO  = r_inizio;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign RESULT  = r_result;
    assign ROUNDS  = r_rounds;
    assign WINS1   = r_wins1;
    assign WINS2   = r_wins2;
    assign ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morra_giocatore.sv
`default_nettype none
// ============================================================================
// Module      : tb_morra_giocatore
// Description : Self-checking bench for morra_giocatore with a game-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morra_giocatore;

    logic       clk;
    logic       RST, START, INJ_INVALID;
    logic [3:0] CFG_LEN;
    logic [7:0] SEED;
    logic [1:0] MANCHE, PARTITA;
    logic [1:0] PRIMO, SECONDO, RESULT;
    logic       INIZIO, BUSY, DONE, ERR;
    logic [4:0] ROUNDS, WINS1, WINS2;

    int total = 0;
    int bad   = 0;

    morra_giocatore dut (
        .clk         (clk),
        .RST         (RST),
        .START       (START),
        .CFG_LEN     (CFG_LEN),
        .SEED        (SEED),
        .INJ_INVALID (INJ_INVALID),
        .MANCHE      (MANCHE),
        .PARTITA     (PARTITA),
        .PRIMO       (PRIMO),
        .SECONDO     (SECONDO),
        .INIZIO      (INIZIO),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .RESULT      (RESULT),
        .ROUNDS      (ROUNDS),
        .WINS1       (WINS1),
        .WINS2       (WINS2),
        .ERR         (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int lfsr_step(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v * 2) % 256) + fb;
    endfunction

    // Rock-paper-scissors on 1..3: P1 wins when it sits one step above P2 (mod 3).
    function automatic int round_result(input int p, input int s);
        if (p == 0 || s == 0) return 0;
        if (p == s)           return 3;
        if ((p + 3 - s) % 3 == 1) return 1;
        return 2;
    endfunction

    // Plays one full game from IDLE. part_at=0: referee never ends the game.
    // lie_cyc: PLAY cycle on which the referee answers lie_val instead of the truth.
    // abort_cyc: PLAY cycle on which RST is asserted instead.
    task automatic run_game(input logic [7:0] seed, input logic [3:0] cfg, input logic inj,
                            input int part_at, input int part_val, input int lie_cyc,
                            input int lie_val, input int abort_cyc, output logic [3:0] first_pair);
        int v, c1, c2, p, s, tm, m, pr, rounds, w1, w2, ban1, ban2;
        bit err, done_m, p1win_b;
        logic [1:0] res;
        v = (seed == 8'h00) ? 32'hA5 : int'(seed);
        rounds = 0; w1 = 0; w2 = 0; ban1 = 0; ban2 = 0;
        err = 0; done_m = 0; p1win_b = 0; res = 2'b00; first_pair = 4'h0;

        START = 1'b1; SEED = seed; CFG_LEN = cfg; INJ_INVALID = inj;
        @(posedge clk); #1;
        START = 1'b0; SEED = 8'($urandom); CFG_LEN = 4'($urandom); INJ_INVALID = 1'($urandom);

        total++;
        if ({INIZIO, BUSY, DONE, PRIMO, SECONDO} !== {3'b110, cfg}) begin
            bad++;
            $display("FAIL init_flags got=%b exp=%b", {INIZIO, BUSY, DONE, PRIMO, SECONDO}, {3'b110, cfg});
        end
        total++;
        if ({RESULT, ROUNDS, WINS1, WINS2, ERR} !== 18'd0) begin
            bad++;
            $display("FAIL init_clear got=%h exp=0", {RESULT, ROUNDS, WINS1, WINS2, ERR});
        end
        @(posedge clk); #1;

        for (int k = 1; k <= 40 && !done_m; k++) begin
            c1 = v % 4;        if (c1 == 0) c1 = 3; if (c1 == ban1) c1 = c1 % 3 + 1;
            c2 = (v / 4) % 4;  if (c2 == 0) c2 = 3; if (c2 == ban2) c2 = c2 % 3 + 1;
            p = (inj && k == 3) ? 0 : c1;
            s = c2;
            if (k == 1) first_pair = {PRIMO, SECONDO};

            if (p1win_b) begin
                total++;
                if (PRIMO === 2'b10) begin
                    bad++;
                    $display("FAIL restrict got=%b exp=not 10", PRIMO);
                end
            end
            total++;
            if ({PRIMO, SECONDO, INIZIO, BUSY, DONE} !== {p[1:0], s[1:0], 3'b010}) begin
                bad++;
                $display("FAIL play_moves cyc=%0d got=%b exp=%b", k,
                         {PRIMO, SECONDO, INIZIO, BUSY, DONE}, {p[1:0], s[1:0], 3'b010});
            end
            total++;
            if ({ROUNDS, WINS1, WINS2, ERR} !== {rounds[4:0], w1[4:0], w2[4:0], err}) begin
                bad++;
                $display("FAIL play_counts cyc=%0d got=%h exp=%h", k,
                         {ROUNDS, WINS1, WINS2, ERR}, {rounds[4:0], w1[4:0], w2[4:0], err});
            end

            if (k == abort_cyc) begin
                RST = 1'b1;
                @(posedge clk); #1;
                RST = 1'b0;
                total++;
                if ({PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ROUNDS, WINS1, WINS2, ERR} !== 25'd0) begin
                    bad++;
                    $display("FAIL abort_zero got=%h exp=0",
                             {PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ROUNDS, WINS1, WINS2, ERR});
                end
                return;
            end

            tm = round_result(p, s);
            m  = (k == lie_cyc) ? lie_val : tm;
            if (m != tm) err = 1;
            p1win_b = 0;
            if (m != 0) begin
                rounds = (rounds < 31) ? rounds + 1 : 31;
                if (m == 1) begin
                    w1 = (w1 < 31) ? w1 + 1 : 31; ban1 = p; p1win_b = (p == 2);
                end else if (m == 2) begin
                    w2 = (w2 < 31) ? w2 + 1 : 31; ban2 = s;
                end else begin
                    ban1 = 0; ban2 = 0;
                end
            end
            pr = (part_at != 0 && m != 0 && rounds == part_at) ? part_val : 0;
            MANCHE = m[1:0]; PARTITA = pr[1:0];
            if (k == 2) begin START = 1'b1; SEED = 8'($urandom); end
            @(posedge clk); #1;
            START = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00;
            v = lfsr_step(v);
            if (pr != 0) begin
                res = pr[1:0]; done_m = 1;
            end else if (rounds >= 20) begin
                err = 1; res = 2'b00; done_m = 1;
            end
        end

        total++;
        if ({DONE, BUSY, INIZIO, PRIMO, SECONDO} !== 7'b1000000) begin
            bad++;
            $display("FAIL finish_flags got=%b exp=1000000", {DONE, BUSY, INIZIO, PRIMO, SECONDO});
        end
        total++;
        if ({RESULT, ROUNDS, WINS1, WINS2, ERR} !== {res, rounds[4:0], w1[4:0], w2[4:0], err}) begin
            bad++;
            $display("FAIL finish_vals got=%h exp=%h", {RESULT, ROUNDS, WINS1, WINS2, ERR},
                     {res, rounds[4:0], w1[4:0], w2[4:0], err});
        end
        START = 1'b1; SEED = 8'($urandom);
        @(posedge clk); #1;
        START = 1'b0;
        total++;
        if ({DONE, BUSY, INIZIO, RESULT} !== {3'b000, res}) begin
            bad++;
            $display("FAIL idle_after got=%b exp=%b", {DONE, BUSY, INIZIO, RESULT}, {3'b000, res});
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; CFG_LEN = 4'h0; SEED = 8'h00; INJ_INVALID = 1'b0;
        MANCHE = 2'b00; PARTITA = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0; RST = 1'b0;
        total++;
        if ({PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ROUNDS, WINS1, WINS2, ERR} !== 25'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0",
                     {PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ROUNDS, WINS1, WINS2, ERR});
        end
    endtask

    task automatic test_first_moves();
        logic [3:0] fp;
        run_game(8'h00, 4'h0, 1'b0, 3, 3, 0, 0, 0, fp);
        total++;
        if (fp !== 4'b0101) begin
            bad++;
            $display("FAIL first_moves got=%b exp=0101", fp);
        end
    endtask

    task automatic test_partita();
        logic [3:0] fp;
        run_game(8'h3C, 4'h7, 1'b0, 5, 2, 0, 0, 0, fp);
        total++;
        if ({RESULT, ROUNDS, BUSY, ERR} !== {2'b10, 5'd5, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL partita_end got=%b exp=%b", {RESULT, ROUNDS, BUSY, ERR}, {2'b10, 5'd5, 1'b0, 1'b0});
        end
    endtask

    task automatic test_invalid();
        logic [3:0] fp;
        run_game(8'h5A, 4'h2, 1'b1, 6, 1, 0, 0, 0, fp);
        total++;
        if ({ROUNDS, ERR} !== {5'd6, 1'b0}) begin
            bad++;
            $display("FAIL invalid_ok got=%b exp=%b", {ROUNDS, ERR}, {5'd6, 1'b0});
        end
        run_game(8'h5A, 4'h2, 1'b1, 6, 1, 3, 1, 0, fp);
        total++;
        if (ERR !== 1'b1) begin
            bad++;
            $display("FAIL invalid_lie got=%b exp=1", ERR);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] fp;
        run_game(8'h81, 4'hF, 1'b0, 0, 0, 0, 0, 0, fp);
        total++;
        if ({RESULT, ROUNDS, ERR} !== {2'b00, 5'd20, 1'b1}) begin
            bad++;
            $display("FAIL timeout got=%b exp=%b", {RESULT, ROUNDS, ERR}, {2'b00, 5'd20, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] fp;
        run_game(8'hC3, 4'h1, 1'b0, 0, 0, 0, 0, 8, fp);
        run_game(8'hC3, 4'h1, 1'b0, 4, 3, 0, 0, 0, fp);
        total++;
        if ({RESULT, ROUNDS, ERR} !== {2'b11, 5'd4, 1'b0}) begin
            bad++;
            $display("FAIL clean_after_rst got=%b exp=%b", {RESULT, ROUNDS, ERR}, {2'b11, 5'd4, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fp;
        for (int g = 0; g < 8; g++) begin
            run_game(8'($urandom), 4'($urandom), 1'($urandom), $urandom_range(1, 24),
                     $urandom_range(1, 3), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                     $urandom_range(0, 3), 0, fp);
        end
    endtask

    initial begin
        test_reset();
        test_first_moves();
        test_partita();
        test_invalid();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
